// File: rtl/maze_pkg.sv
// Shared definitions for the maze ROM arbiter block.
//   MAZE_ADDR_W / MAZE_DATA_W : geometry of the single-port maze ROM
//   rom_arb_state_t           : arbiter transaction phases
package maze_pkg;

  localparam int MAZE_ADDR_W = 11;
  localparam int MAZE_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } rom_arb_state_t;

endpackage

// File: rtl/maze_rom_arbiter_rr_picker.sv
// Combinational rotating-priority picker.
// Scans i_req starting at bit i_ptr and moving upward, wrapping at NUM_REQ,
// and reports the first set bit.
//   i_req    : request vector
//   i_ptr    : index holding highest priority
//   o_onehot : one-hot of the winning requester (all zero if none)
//   o_idx    : binary index of the winner (0 if none)
//   o_any    : at least one request present
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int o = 0; o < NUM_REQ; o++) begin
      int k;
      k = int'(i_ptr) + o;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!o_any && i_req[k]) begin
        o_any       = 1'b1;
        o_idx       = IDX_W'(k);
        o_onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/maze_rom_arbiter.sv
// Round-robin arbiter sharing the single-port maze ROM between NUM_REQ
// requesters, one read in flight at a time. All outputs are registered.
//   clk, rst    : clock, asynchronous active-low reset
//   i_req       : per-requester level request, held until its o_rvalid
//   i_addr      : packed addresses, slice k = [k*ADDR_W +: ADDR_W]
//   o_gnt       : one-hot owner of the current transaction
//   o_rvalid    : one-cycle pulse, o_rdata valid for the flagged requester
//   o_rdata     : returned ROM word, holds its last value outside RESP
//   o_rom_en    : ROM read enable (high for exactly one cycle per read)
//   o_rom_addr  : ROM address, latched when the winner is picked
//   i_rom_data  : ROM read data, valid ROM_LAT cycles after the enable edge
//   o_busy      : high whenever a transaction is in progress
module maze_rom_arbiter
  import maze_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = MAZE_ADDR_W,
  parameter int DATA_W  = MAZE_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_rom_en,
  output logic [ADDR_W-1:0]         o_rom_addr,
  input  logic [DATA_W-1:0]         i_rom_data,
  output logic                      o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ROM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_LAT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  rom_arb_state_t      state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rom_en_q, rom_en_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req    (i_req),
    .i_ptr    (ptr_q),
    .o_onehot (pick_onehot),
    .o_idx    (pick_idx),
    .o_any    (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr_q;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_any) begin
          gnt_d      = pick_onehot;
          win_d      = pick_idx;
          rom_addr_d = i_addr[pick_idx*ADDR_W +: ADDR_W];
          rom_en_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // Enable was already visible during ISSUE; it drops for WAIT.
        cnt_d   = CNT_LOAD;
        ptr_d   = (win_q == IDX_LAST) ? '0 : win_q + IDX_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d  = i_rom_data;
          rvalid_d = gnt_q;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_rvalid   = rvalid_q;
  assign o_rdata    = rdata_q;
  assign o_rom_en   = rom_en_q;
  assign o_rom_addr = rom_addr_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_maze_rom_arbiter.sv
// Bench for maze_rom_arbiter: two instances (ROM_LAT=1 and ROM_LAT=3),
// each backed by a registered ROM model, checked every cycle against a
// transaction-timeline reference model plus directed scenario checks.
module tb_maze_rom_arbiter;

  localparam int N  = 2;
  localparam int AW = 11;
  localparam int DW = 16;

  logic clk;
  logic rst;

  logic [N-1:0]    req      [2];
  logic [N*AW-1:0] addr     [2];
  logic [N-1:0]    gnt      [2];
  logic [N-1:0]    rvalid   [2];
  logic [DW-1:0]   rdata    [2];
  logic            rom_en   [2];
  logic [AW-1:0]   rom_addr [2];
  logic [DW-1:0]   rom_data [2];
  logic            busy     [2];

  int checks   = 0;
  int failures = 0;

  // reference model state per instance
  int            mp   [2];
  int            mptr [2];
  int            mw   [2];
  logic [AW-1:0] maddr[2];
  logic [DW-1:0] mrd  [2];
  int            en_cnt [2];

  bit auto_drop;
  bit rand_mode;
  int cyc;

  maze_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req[0]),
    .i_addr     (addr[0]),
    .o_gnt      (gnt[0]),
    .o_rvalid   (rvalid[0]),
    .o_rdata    (rdata[0]),
    .o_rom_en   (rom_en[0]),
    .o_rom_addr (rom_addr[0]),
    .i_rom_data (rom_data[0]),
    .o_busy     (busy[0])
  );

  maze_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req[1]),
    .i_addr     (addr[1]),
    .o_gnt      (gnt[1]),
    .o_rvalid   (rvalid[1]),
    .o_rdata    (rdata[1]),
    .o_rom_en   (rom_en[1]),
    .o_rom_addr (rom_addr[1]),
    .i_rom_data (rom_data[1]),
    .o_busy     (busy[1])
  );

  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
    return {5'h0, a} ^ 16'hA5A5;
  endfunction

  // ROM models: data appears only for an enabled read, exactly ROM_LAT deep.
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [3];

  always_ff @(posedge clk) begin
    pipe1    <= rom_en[0] ? romf(rom_addr[0]) : 16'hDEAD;
    pipe3[0] <= rom_en[1] ? romf(rom_addr[1]) : 16'hDEAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign rom_data[0] = pipe1;
  assign rom_data[1] = pipe3[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int i);
    mp[i]    = 0;
    mptr[i]  = 0;
    mw[i]    = 0;
    maddr[i] = '0;
    mrd[i]   = '0;
  endtask

  // Transaction timeline: decision cycle, then phases 1..2+L; phase 1 carries
  // the ROM enable, phase 2+L carries the response.
  task automatic model_edge(input int i);
    int lat;
    lat = (i == 0) ? 1 : 3;
    if (!rst) begin
      model_reset(i);
    end else if (mp[i] == 0) begin
      if (req[i] != '0) begin
        int w;
        w = -1;
        for (int o = 0; o < N; o++) begin
          int k;
          k = (mptr[i] + o) % N;
          if (w < 0 && req[i][k]) w = k;
        end
        mw[i]    = w;
        maddr[i] = addr[i][w*AW +: AW];
        mptr[i]  = (w + 1) % N;
        mp[i]    = 1;
      end
    end else if (mp[i] == 2 + lat) begin
      mp[i] = 0;
    end else begin
      mp[i] = mp[i] + 1;
      if (mp[i] == 2 + lat) mrd[i] = romf(maddr[i]);
    end
  endtask

  task automatic compare(input int i);
    int lat;
    bit act;
    lat = (i == 0) ? 1 : 3;
    act = (mp[i] != 0);
    check_eq($sformatf("gnt[%0d]", i), 32'(gnt[i]), act ? (32'd1 << mw[i]) : 32'd0);
    check_eq($sformatf("rvalid[%0d]", i), 32'(rvalid[i]),
             (mp[i] == 2 + lat) ? (32'd1 << mw[i]) : 32'd0);
    check_eq($sformatf("rom_en[%0d]", i), 32'(rom_en[i]), 32'(mp[i] == 1));
    check_eq($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(act));
    check_eq($sformatf("rdata[%0d]", i), 32'(rdata[i]), 32'(mrd[i]));
    check_eq($sformatf("rom_addr[%0d]", i), 32'(rom_addr[i]), 32'(maddr[i]));
  endtask

  task automatic stim();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < N; k++) begin
        if (auto_drop && rvalid[i][k]) begin
          req[i][k] = 1'b0;
        end else if (rand_mode) begin
          if (!req[i][k]) begin
            if ($urandom_range(0, 3) == 0) begin
              addr[i][k*AW +: AW] = AW'($urandom);
              req[i][k] = 1'b1;
            end
          end else if ($urandom_range(0, 29) == 0) begin
            req[i][k] = 1'b0;
          end else if ($urandom_range(0, 19) == 0) begin
            addr[i][k*AW +: AW] = AW'($urandom);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      compare(i);
      if (rom_en[i]) en_cnt[i]++;
    end
    stim();
  endtask

  task automatic wait_rv(input int i, input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (rvalid[i] == '0 && n < maxc);
    check_eq($sformatf("rvalid_seen[%0d]", i), 32'(rvalid[i] != '0), 32'd1);
  endtask

  task automatic reset_all();
    req[0] = '0;
    req[1] = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst       = 1'b0;
    auto_drop = 1'b1;
    rand_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i]    = '0;
      addr[i]   = '0;
      en_cnt[i] = 0;
      model_reset(i);
    end
    #1;
    check_eq("reset_gnt", 32'(gnt[0]), 32'd0);
    check_eq("reset_busy", 32'(busy[0]), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // 1: single request, ROM_LAT=1
    addr[0][0 +: AW] = 11'h123;
    req[0] = 2'b01;
    en_cnt[0] = 0;
    wait_rv(0, 20, cyc);
    check_eq("t1_latency", 32'(cyc), 32'd3);
    check_eq("t1_rvalid", 32'(rvalid[0]), 32'h1);
    check_eq("t1_rdata", 32'(rdata[0]), 32'hA486);
    repeat (3) tick();
    check_eq("t1_en_cycles", 32'(en_cnt[0]), 32'd1);

    // 2: both requesting continuously, grants alternate
    reset_all();
    auto_drop = 1'b0;
    addr[0] = {11'h020, 11'h010};
    req[0] = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_rv(0, 20, cyc);
      check_eq("t2_order", 32'(rvalid[0]), (n % 2 == 1) ? 32'h2 : 32'h1);
      check_eq("t2_data", 32'(rdata[0]), 32'(romf((n % 2 == 1) ? 11'h020 : 11'h010)));
    end
    req[0] = '0;
    repeat (2) tick();

    // 3: single persistent requester 1, back-to-back
    addr[0][AW +: AW] = 11'h055;
    req[0] = 2'b10;
    for (int n = 0; n < 4; n++) begin
      wait_rv(0, 20, cyc);
      check_eq("t3_gnt", 32'(gnt[0]), 32'h2);
      if (n > 0) check_eq("t3_spacing", 32'(cyc), 32'd4);
    end
    req[0] = '0;
    auto_drop = 1'b1;
    repeat (2) tick();

    // 4: asynchronous reset in WAIT
    addr[0][0 +: AW] = 11'h0AA;
    req[0] = 2'b01;
    tick();
    tick();
    rst = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    for (int i = 0; i < 2; i++) compare(i);
    check_eq("t4_async_busy", 32'(busy[0]), 32'd0);
    req[0] = '0;
    tick();
    tick();
    rst = 1'b1;
    cyc = 0;
    repeat (6) begin
      tick();
      if (rvalid[0] != '0) cyc++;
    end
    check_eq("t4_no_rvalid", 32'(cyc), 32'd0);
    addr[0] = {11'h0BB, 11'h0CC};
    req[0] = 2'b11;
    tick();
    check_eq("t4_first_gnt", 32'(gnt[0]), 32'h1);
    repeat (12) tick();

    // 5: ROM_LAT=3 instance
    en_cnt[1] = 0;
    addr[1][0 +: AW] = 11'h7FF;
    req[1] = 2'b01;
    wait_rv(1, 20, cyc);
    check_eq("t5_latency", 32'(cyc), 32'd5);
    check_eq("t5_rdata", 32'(rdata[1]), 32'hA25A);
    repeat (3) tick();
    check_eq("t5_en_cycles", 32'(en_cnt[1]), 32'd1);

    // 6: requester 0 drops early, requester 1 waiting
    reset_all();
    addr[0] = {11'h222, 11'h111};
    req[0] = 2'b11;
    tick();
    check_eq("t6_gnt0", 32'(gnt[0]), 32'h1);
    tick();
    req[0][0] = 1'b0;
    wait_rv(0, 20, cyc);
    check_eq("t6_rvalid0", 32'(rvalid[0]), 32'h1);
    tick();
    tick();
    check_eq("t6_gnt1", 32'(gnt[0]), 32'h2);
    repeat (8) tick();

    // randomized traffic on both instances
    rand_mode = 1'b1;
    repeat (3000) tick();
    rand_mode = 1'b0;
    req[0] = '0;
    req[1] = '0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
